ram_1r_nw_byte_mask_sync: RTL and testbench
===========================================

# ram_1r_nw_byte_mask_sync

- Synchronous RAM with one dedicated read port and `write_ports_p` independent byte-masked write ports, all usable in the same cycle.
- Each write port owns a private bank. A per-byte live-value table (LVT) records which bank last wrote each byte, and the read path assembles the word byte by byte from all banks.
- Partial writes from different ports to the same entry merge correctly.
- Replaces the two-bank 1rw/1w banked RAM in TCP buffer and state-table paths that need more concurrent writers.

## Interface

Parameters:
- `width_p`, -1, data width in bits; must be a multiple of 8.
- `els_p`, -1, number of entries.
- `write_ports_p`, 2, number of write ports; must be ≥1.
- `addr_width_lp`, `BSG_SAFE_CLOG2(els_p)`, address width.
- `mask_width_lp`, `width_p/8`, byte-mask width.
- `bank_sel_width_lp`, `BSG_SAFE_CLOG2(write_ports_p)`, LVT entry width per byte.

Ports:
- `clk_i` in 1: the single clock.
- `reset_i` in 1: synchronous, active-high reset.
- `w_v_i` in `write_ports_p`: per-port write valid.
- `w_addr_i` in `write_ports_p*addr_width_lp`: write addresses; port k occupies slice k.
- `w_data_i` in `write_ports_p*width_p`: write data, sliced the same way.
- `w_mask_i` in `write_ports_p*mask_width_lp`: byte enables; bit j enables byte j.
- `r_v_i` in 1: read request.
- `r_addr_i` in `addr_width_lp`: read address.
- `r_v_o` out 1: read data valid, one cycle after `r_v_i`.
- `r_data_o` out `width_p`: read data; forced to 0 when `r_v_o`=0.

## Operation

Banks:
- Bank k is a 1r1w byte-mask sync memory, `els_p` x `width_p`.
- Bank k is written only by port k: write enable = `w_v_i[k]`, mask = `w_mask_i[k]`.
- All banks are read at `r_addr_i` when `r_v_i`=1.

LVT:
- Flop array of `els_p` x `mask_width_lp` entries, each `bank_sel_width_lp` bits.
- On a write from port k with mask bit j set, entry [addr][j] is set to k on the next edge.
- Unmasked bytes leave their LVT entries unchanged.

Write collision:
- If several ports write the same address and byte in one cycle, all of them write their own banks.
- The LVT records the highest-index port among them, so the highest index wins.

Read path:
- At the read edge, `r_addr_i`, `r_v_i` and the LVT row for `r_addr_i` (pre-update values) are registered.
- In the next cycle, byte j of `r_data_o` = byte j of bank[lvt_row_q[j]].

Reset:
- While `reset_i`=1, all LVT entries are cleared to 0 and all writes are suppressed (bank write enables forced low).
- `r_v_o`=0 during reset and on the first cycle after reset, so `r_data_o`=0.
- Bank contents are not cleared. A read of a never-written entry returns undefined data with `r_v_o`=1.

Reset mid-operation:
- A read accepted in the cycle `reset_i` rises is dropped: `r_v_o`=0 next cycle.
- Writes in that cycle are lost.

`write_ports_p`=1:
- The LVT is removed, and `r_data_o` is bank 0 data gated by `r_v_o`.

## Timing

Read latency:
- `r_v_i` at edge t gives `r_v_o`=1 and data in cycle t+1.
- Fully pipelined: one read per cycle, no backpressure.

Write latency:
- A write at edge t is visible to a read issued at edge t+1 or later.

Same-cycle read and write to the same address (edge t):
- Without bypass, each byte returns its pre-write value.
- With `RAM_1R_NW_WRITE_BYPASS_EN`, see Configuration.

Other rules:
- No handshake on writes: every valid write is accepted in the cycle presented.
- Addresses ≥ `els_p` are illegal and are flagged only in simulation: assertion when the corresponding valid is set.

## Configuration

`RAM_1R_NW_WRITE_BYPASS_EN`:
- When defined, reads see same-cycle writes. At a read edge, bytes written in that same cycle to `r_addr_i` are captured into a bypass register (highest-index port wins per byte). `r_data_o` uses the bypassed bytes in place of the bank bytes, giving write-first behaviour.
- When undefined, no bypass logic is built and same-cycle reads return old data per byte (read-first).

## Test plan

- Reset, then read address 5: `r_v_o`=0 during reset, and `r_v_o`=1 one cycle after the read with no X on the LVT select.
- Port 0 writes 0xAABBCCDD, mask 4'hF, to addr 3. Next cycle port 1 writes 0x11 with mask 4'h1. A read of addr 3 returns 0xAABBCC11.
- Ports 0 and 1 write addr 7 in the same cycle with 0x01010101 and 0x02020202, mask 4'hF. A later read returns 0x02020202.
- Disjoint masks in the same cycle: port 0 writes 0x000000EE with mask 4'h1 and port 1 writes 0xFF000000 with mask 4'h8 to addr 9, after addr 9 was initialised to 0. A read returns 0xFF0000EE.
- Same-cycle read and write: addr 2 holds 0x12345678; port 1 writes 0xDEADBEEF with mask 4'hC while addr 2 is read.
  - Without the macro: 0x12345678.
  - With the macro: 0xDEAD5678.
- Back-to-back reads of addrs 0..15 every cycle while both ports stream writes to addrs 16..31: each read returns the expected value one cycle later, `r_v_o` stays continuously high, and `reset_i` asserted mid-stream drops the in-flight read.

Source files
------------

// File: rtl/ram_1r_nw_byte_mask_sync.sv
// ram_1r_nw_byte_mask_sync: 1 read port, write_ports_p byte-masked write ports, LVT-merged banks
//   clk_i/reset_i         : clock, synchronous active-high reset
//   w_v_i/w_addr_i/
//   w_data_i/w_mask_i     : per-port write valid/address/data/byte mask, port k in slice k
//   r_v_i/r_addr_i        : read request and address
//   r_v_o/r_data_o        : read valid and data one cycle later (data is 0 when not valid)
//   RAM_1R_NW_WRITE_BYPASS_EN : when defined, same-cycle writes are forwarded to the read (write-first)
module ram_1r_nw_byte_mask_sync #(
  parameter int width_p = 32,
  parameter int els_p = 32,
  parameter int write_ports_p = 2,
  parameter int addr_width_lp = (els_p == 1) ? 1 : $clog2(els_p),
  parameter int mask_width_lp = width_p / 8,
  parameter int bank_sel_width_lp = (write_ports_p == 1) ? 1 : $clog2(write_ports_p)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [write_ports_p-1:0]               w_v_i,
  input  logic [write_ports_p*addr_width_lp-1:0] w_addr_i,
  input  logic [write_ports_p*width_p-1:0]       w_data_i,
  input  logic [write_ports_p*mask_width_lp-1:0] w_mask_i,
  input  logic                                   r_v_i,
  input  logic [addr_width_lp-1:0]               r_addr_i,
  output logic                                   r_v_o,
  output logic [width_p-1:0]                     r_data_o
);
  logic r_v_q;
  logic [write_ports_p-1:0][width_p-1:0] bank_rd;
  logic [mask_width_lp-1:0][bank_sel_width_lp-1:0] sel_q;
  logic [mask_width_lp-1:0] byp_v_q;
  logic [width_p-1:0] byp_d_q;
  always_ff @(posedge clk_i) r_v_q <= !reset_i && r_v_i;
  assign r_v_o = r_v_q;
  for (genvar k = 0; k < write_ports_p; k++) begin : g_bank
    logic [width_p-1:0] mem [els_p];
    logic [width_p-1:0] rd_q;
    logic [addr_width_lp-1:0] wa;
    assign wa = w_addr_i[k*addr_width_lp +: addr_width_lp];
    always_ff @(posedge clk_i) begin
      if (w_v_i[k] && !reset_i)
        for (int j = 0; j < mask_width_lp; j++)
          if (w_mask_i[k*mask_width_lp+j]) mem[wa][j*8 +: 8] <= w_data_i[k*width_p+j*8 +: 8];
      if (r_v_i && !reset_i) rd_q <= mem[r_addr_i];
    end
    assign bank_rd[k] = rd_q;
  end
  if (write_ports_p > 1) begin : g_lvt
    logic [mask_width_lp-1:0][bank_sel_width_lp-1:0] lvt [els_p];
    // Ports are scanned low to high so the highest-index writer of a byte lands last.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        for (int e = 0; e < els_p; e++) lvt[e] <= '0;
        sel_q <= '0;
      end else begin
        for (int k = 0; k < write_ports_p; k++)
          for (int j = 0; j < mask_width_lp; j++)
            if (w_v_i[k] && w_mask_i[k*mask_width_lp+j])
              lvt[w_addr_i[k*addr_width_lp +: addr_width_lp]][j] <= bank_sel_width_lp'(k);
        if (r_v_i) sel_q <= lvt[r_addr_i];
      end
    end
  end else begin : g_no_lvt
    assign sel_q = '0;
  end
`ifdef RAM_1R_NW_WRITE_BYPASS_EN
  logic [mask_width_lp-1:0] byp_v;
  logic [width_p-1:0] byp_d;
  always_comb begin
    byp_v = '0;
    byp_d = '0;
    for (int k = 0; k < write_ports_p; k++)
      for (int j = 0; j < mask_width_lp; j++)
        if (w_v_i[k] && w_mask_i[k*mask_width_lp+j] && w_addr_i[k*addr_width_lp +: addr_width_lp] == r_addr_i) begin
          byp_v[j] = 1'b1;
          byp_d[j*8 +: 8] = w_data_i[k*width_p+j*8 +: 8];
        end
  end
  always_ff @(posedge clk_i)
    if (r_v_i && !reset_i) begin
      byp_v_q <= byp_v;
      byp_d_q <= byp_d;
    end
`else
  assign byp_v_q = '0;
  assign byp_d_q = '0;
`endif
  always_comb begin
    r_data_o = '0;
    for (int j = 0; j < mask_width_lp; j++)
      r_data_o[j*8 +: 8] = !r_v_q ? 8'h00 : byp_v_q[j] ? byp_d_q[j*8 +: 8] : bank_rd[sel_q[j]][j*8 +: 8];
  end
`ifndef SYNTHESIS
  localparam logic [addr_width_lp:0] els_lp = (addr_width_lp+1)'(els_p);
  always_ff @(posedge clk_i)
    if (!reset_i) begin
      for (int k = 0; k < write_ports_p; k++)
        assert (!w_v_i[k] || {1'b0, w_addr_i[k*addr_width_lp +: addr_width_lp]} < els_lp);
      assert (!r_v_i || {1'b0, r_addr_i} < els_lp);
    end
`endif
endmodule

// File: tb/tb_ram_1r_nw_byte_mask_sync.sv
// tb_ram_1r_nw_byte_mask_sync: directed self-checking bench for the 2-write-port LVT RAM
module tb_ram_1r_nw_byte_mask_sync;
  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  logic [1:0] w_v_i = '0;
  logic [9:0] w_addr_i = '0;
  logic [63:0] w_data_i = '0;
  logic [7:0] w_mask_i = '0;
  logic r_v_i = 1'b0;
  logic [4:0] r_addr_i = '0;
  logic r_v_o;
  logic [31:0] r_data_o;
  int checks = 0;
  int errors = 0;
  ram_1r_nw_byte_mask_sync #(.width_p(32), .els_p(32), .write_ports_p(2)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .w_v_i(w_v_i), .w_addr_i(w_addr_i),
    .w_data_i(w_data_i), .w_mask_i(w_mask_i), .r_v_i(r_v_i), .r_addr_i(r_addr_i),
    .r_v_o(r_v_o), .r_data_o(r_data_o)
  );
  always #5 clk_i = ~clk_i;
  function automatic logic [31:0] f(input int a);
    return {8'hA5, 8'(a), 8'(~a), 8'(a * 3)};
  endfunction
  function automatic logic [31:0] g(input int i);
    return 32'h5A000000 | 32'(i);
  endfunction
  task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0, input logic [3:0] m0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1, input logic [3:0] m1,
                       input logic rv, input logic [4:0] ra);
    w_v_i = {v1, v0};
    w_addr_i = {a1, a0};
    w_data_i = {d1, d0};
    w_mask_i = {m1, m0};
    r_v_i = rv;
    r_addr_i = ra;
    @(posedge clk_i);
    #1;
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic rd(input logic [4:0] a);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, a);
  endtask
  task automatic test_reset();
    reset_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rd(5);
      checks++;
      if (r_v_o !== 1'b0 || r_data_o !== 32'h0) begin
        $display("FAIL reset_hold: r_v_o=%b r_data_o=%h, required 0/00000000", r_v_o, r_data_o);
        errors++;
      end
    end
    reset_i = 1'b0;
    #1;
    checks++;
    if (r_v_o !== 1'b0) begin
      $display("FAIL reset_first_cycle: r_v_o=%b, required 0", r_v_o);
      errors++;
    end
    @(posedge clk_i);
    #1;
    checks++;
    if (r_v_o !== 1'b1) begin
      $display("FAIL reset_read5_valid: r_v_o=%b, required 1", r_v_o);
      errors++;
    end
    idle();
    checks++;
    if (r_v_o !== 1'b0 || r_data_o !== 32'h0) begin
      $display("FAIL idle_gate: r_v_o=%b r_data_o=%h, required 0/00000000", r_v_o, r_data_o);
      errors++;
    end
  endtask
  task automatic test_merge();
    drive(1, 3, 32'hAABBCCDD, 4'hF, 0, 0, 0, 0, 0, 0);
    rd(3);
    checks++;
    if (r_data_o !== 32'hAABBCCDD || r_v_o !== 1'b1) begin
      $display("FAIL merge_full: r_data_o=%h r_v_o=%b, required aabbccdd/1", r_data_o, r_v_o);
      errors++;
    end
    drive(0, 0, 0, 0, 1, 3, 32'h00000011, 4'h1, 0, 0);
    rd(3);
    checks++;
    if (r_data_o !== 32'hAABBCC11) begin
      $display("FAIL merge_partial: r_data_o=%h, required aabbcc11", r_data_o);
      errors++;
    end
  endtask
  task automatic test_collision();
    drive(1, 7, 32'h01010101, 4'hF, 1, 7, 32'h02020202, 4'hF, 0, 0);
    drive(1, 8, 32'hAAAAAAAA, 4'hF, 1, 8, 32'hBBBBBBBB, 4'h6, 0, 0);
    rd(7);
    checks++;
    if (r_data_o !== 32'h02020202) begin
      $display("FAIL collision_full: r_data_o=%h, required 02020202", r_data_o);
      errors++;
    end
    rd(8);
    checks++;
    if (r_data_o !== 32'hAABBBBAA) begin
      $display("FAIL collision_partial: r_data_o=%h, required aabbbbaa", r_data_o);
      errors++;
    end
  endtask
  task automatic test_disjoint();
    drive(1, 9, 32'h0, 4'hF, 0, 0, 0, 0, 0, 0);
    drive(1, 9, 32'h000000EE, 4'h1, 1, 9, 32'hFF000000, 4'h8, 0, 0);
    rd(9);
    checks++;
    if (r_data_o !== 32'hFF0000EE) begin
      $display("FAIL disjoint: r_data_o=%h, required ff0000ee", r_data_o);
      errors++;
    end
  endtask
  task automatic test_same_cycle();
    logic [31:0] exp;
`ifdef RAM_1R_NW_WRITE_BYPASS_EN
    exp = 32'hDEAD5678;
`else
    exp = 32'h12345678;
`endif
    drive(1, 2, 32'h12345678, 4'hF, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 2, 32'hDEADBEEF, 4'hC, 1, 2);
    checks++;
    if (r_data_o !== exp) begin
      $display("FAIL same_cycle: r_data_o=%h, required %h", r_data_o, exp);
      errors++;
    end
    rd(2);
    checks++;
    if (r_data_o !== 32'hDEAD5678) begin
      $display("FAIL after_same_cycle: r_data_o=%h, required dead5678", r_data_o);
      errors++;
    end
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) drive(1, 5'(i), f(i), 4'hF, 1, 5'(i + 8), f(i + 8), 4'hF, 0, 0);
    for (int i = 0; i < 16; i++) begin
      drive(1, 5'(16 + i), g(i), 4'hF, 1, 5'(31 - i), 32'hC3C3C3C3 ^ 32'(i), 4'hF, 1, 5'(i));
      checks++;
      if (r_v_o !== 1'b1 || r_data_o !== f(i)) begin
        $display("FAIL stream_read%0d: r_v_o=%b r_data_o=%h, required 1/%h", i, r_v_o, r_data_o, f(i));
        errors++;
      end
    end
    reset_i = 1'b1;
    drive(1, 20, 32'h55555555, 4'hF, 0, 0, 0, 0, 1, 0);
    checks++;
    if (r_v_o !== 1'b0 || r_data_o !== 32'h0) begin
      $display("FAIL stream_reset_drop: r_v_o=%b r_data_o=%h, required 0/00000000", r_v_o, r_data_o);
      errors++;
    end
    reset_i = 1'b0;
    idle();
    rd(16);
    checks++;
    if (r_data_o !== g(0)) begin
      $display("FAIL post_reset_16: r_data_o=%h, required %h", r_data_o, g(0));
      errors++;
    end
    rd(20);
    checks++;
    if (r_data_o !== g(4)) begin
      $display("FAIL reset_write_lost: r_data_o=%h, required %h", r_data_o, g(4));
      errors++;
    end
    rd(8);
    checks++;
    if (r_data_o !== 32'hAAAAAAAA) begin
      $display("FAIL lvt_cleared: r_data_o=%h, required aaaaaaaa", r_data_o);
      errors++;
    end
  endtask
  initial begin
    test_reset();
    test_merge();
    test_collision();
    test_disjoint();
    test_same_cycle();
    test_back_to_back();
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
